// File: rtl/mux_pkg.sv
// Shared mode encodings, default sizing and index-width helper for valid_mux_rr.
package mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  localparam int DEF_N_CH = 4;
  localparam int DEF_DW   = 8;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first asserted req at or after ptr,
// wrapping from N_CH-1 back to 0 for any N_CH (not just powers of two).
module rr_pick
  import mux_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int SW   = idx_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [SW-1:0]   ptr,
  output logic            gnt_vld,
  output logic [SW-1:0]   gnt_idx
);

  logic [2*N_CH-1:0] req2;
  logic [N_CH-1:0]   rot;
  logic [SW:0]       sum;

  always_comb begin
    req2    = {req, req} >> ptr;
    rot     = req2[N_CH-1:0];
    gnt_vld = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int unsigned j = 0; j < N_CH; j++) begin
      if (!gnt_vld && rot[j]) begin
        gnt_vld = 1'b1;
        // Offset from ptr wrapped by compare so non-power-of-two N_CH works.
        sum = {1'b0, ptr} + (SW+1)'(j);
        if (sum >= (SW+1)'(N_CH)) sum = sum - (SW+1)'(N_CH);
        gnt_idx = sum[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/valid_mux_rr.sv
// N-channel valid/ready mux with one registered output stage; external-select or
// idle-skipping round-robin. Optional out_par when VALID_MUX_PARITY_EN is defined.
module valid_mux_rr
  import mux_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int DW   = DEF_DW,
  parameter int SW   = idx_w(N_CH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [SW-1:0]      sel,
  input  logic [N_CH-1:0]    in_valid,
  input  logic [N_CH*DW-1:0] in_data,
  output logic [N_CH-1:0]    in_ready,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  output logic [SW-1:0]      out_chan,
`ifdef VALID_MUX_PARITY_EN
  output logic               out_par,
`endif
  input  logic               out_ready
);

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q,  out_data_d;
  logic [SW-1:0] out_chan_q,  out_chan_d;
  logic [SW-1:0] rr_ptr_q,    rr_ptr_d;
`ifdef VALID_MUX_PARITY_EN
  logic          out_par_q,   out_par_d;
`endif

  logic          slot_free;
  logic          rr_vld;
  logic [SW-1:0] rr_idx;
  logic [SW-1:0] cand;
  logic          cand_ok;
  logic          cand_vld;
  logic          grant;
  logic          load;
  logic [DW-1:0] lane_data;

  rr_pick #(
    .N_CH (N_CH),
    .SW   (SW)
  ) u_rr_pick (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt_vld (rr_vld),
    .gnt_idx (rr_idx)
  );

  always_comb begin
    slot_free = !out_valid_q || out_ready;
    cand      = sel;
    cand_ok   = 1'b0;
    if (mode == MODE_RR) begin
      cand    = rr_idx;
      cand_ok = rr_vld;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++)
        if (sel == SW'(i)) cand_ok = 1'b1;
    end
    grant = cand_ok && slot_free && !reset;

    // Decode the candidate once; an out-of-range sel matches no lane.
    in_ready  = '0;
    lane_data = '0;
    cand_vld  = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (cand == SW'(i)) begin
        in_ready[i] = grant;
        lane_data   = in_data[i*DW +: DW];
        cand_vld    = in_valid[i];
      end
    end
    load = grant && cand_vld;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef VALID_MUX_PARITY_EN
    out_par_d   = out_par_q;
`endif
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = lane_data;
      out_chan_d  = cand;
`ifdef VALID_MUX_PARITY_EN
      out_par_d   = ^lane_data;
`endif
      if (mode == MODE_RR)
        rr_ptr_d = (cand == SW'(N_CH-1)) ? '0 : cand + SW'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      rr_ptr_q    <= '0;
`ifdef VALID_MUX_PARITY_EN
      out_par_q   <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef VALID_MUX_PARITY_EN
      out_par_q   <= out_par_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
`ifdef VALID_MUX_PARITY_EN
  assign out_par   = out_par_q;
`endif

endmodule

// File: tb/tb_valid_mux_rr.sv
// Directed bench for valid_mux_rr: 4-lane instance driven from a vector table
// plus hand sequences, and a 3-lane instance for non-power-of-two wrap.
module tb_valid_mux_rr;

  logic clk;
  logic reset;

  logic        m4_mode;
  logic [1:0]  m4_sel;
  logic [3:0]  m4_vld;
  logic [31:0] m4_data;
  logic [3:0]  m4_rdy;
  logic        m4_ov;
  logic [7:0]  m4_od;
  logic [1:0]  m4_oc;
  logic        m4_ordy;

  logic        m3_mode;
  logic [1:0]  m3_sel;
  logic [2:0]  m3_vld;
  logic [23:0] m3_data;
  logic [2:0]  m3_rdy;
  logic        m3_ov;
  logic [7:0]  m3_od;
  logic [1:0]  m3_oc;
  logic        m3_ordy;

`ifdef VALID_MUX_PARITY_EN
  logic m4_par;
  logic m3_par;
`endif

  int checks = 0;
  int errors = 0;

  valid_mux_rr #(.N_CH(4), .DW(8)) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .mode      (m4_mode),
    .sel       (m4_sel),
    .in_valid  (m4_vld),
    .in_data   (m4_data),
    .in_ready  (m4_rdy),
    .out_valid (m4_ov),
    .out_data  (m4_od),
    .out_chan  (m4_oc),
`ifdef VALID_MUX_PARITY_EN
    .out_par   (m4_par),
`endif
    .out_ready (m4_ordy)
  );

  valid_mux_rr #(.N_CH(3), .DW(8)) u_dut3 (
    .clk       (clk),
    .reset     (reset),
    .mode      (m3_mode),
    .sel       (m3_sel),
    .in_valid  (m3_vld),
    .in_data   (m3_data),
    .in_ready  (m3_rdy),
    .out_valid (m3_ov),
    .out_data  (m3_od),
    .out_chan  (m3_oc),
`ifdef VALID_MUX_PARITY_EN
    .out_par   (m3_par),
`endif
    .out_ready (m3_ordy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  vld;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [7:0]  exp_od;
    logic [1:0]  exp_oc;
    logic [1:0]  exp_ptr;
  } vec_t;

  localparam logic [31:0] D_A  = 32'h133C_1110;
  localparam logic [31:0] D_RR = 32'h1312_1110;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1'b0, 2'd2, 4'b0100, D_A,  1'b1, 4'b0100, 1'b1, 8'h3C, 2'd2, 2'd0};
    vecs[1]  = '{1'b0, 2'd3, 4'b0100, D_A,  1'b1, 4'b1000, 1'b0, 8'h3C, 2'd2, 2'd0};
    vecs[2]  = '{1'b1, 2'd0, 4'b1111, D_RR, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0, 2'd1};
    vecs[3]  = '{1'b1, 2'd0, 4'b1111, D_RR, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1, 2'd2};
    vecs[4]  = '{1'b1, 2'd0, 4'b1111, D_RR, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2, 2'd3};
    vecs[5]  = '{1'b1, 2'd0, 4'b1111, D_RR, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3, 2'd0};
    vecs[6]  = '{1'b1, 2'd0, 4'b1111, D_RR, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0, 2'd1};
    vecs[7]  = '{1'b1, 2'd0, 4'b1111, D_RR, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1, 2'd2};
    vecs[8]  = '{1'b1, 2'd0, 4'b1111, D_RR, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2, 2'd3};
    vecs[9]  = '{1'b1, 2'd0, 4'b1111, D_RR, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3, 2'd0};
    vecs[10] = '{1'b1, 2'd0, 4'b1010, D_RR, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1, 2'd2};
    vecs[11] = '{1'b1, 2'd0, 4'b1010, D_RR, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3, 2'd0};
    vecs[12] = '{1'b1, 2'd0, 4'b1010, D_RR, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1, 2'd2};
    vecs[13] = '{1'b1, 2'd0, 4'b1010, D_RR, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3, 2'd0};
    vecs[14] = '{1'b1, 2'd0, 4'b0000, D_RR, 1'b1, 4'b0000, 1'b0, 8'h13, 2'd3, 2'd0};

    reset   = 1'b1;
    m4_mode = 1'b0; m4_sel = 2'd0; m4_vld = 4'b1111; m4_data = D_RR; m4_ordy = 1'b1;
    m3_mode = 1'b1; m3_sel = 2'd0; m3_vld = 3'b000;  m3_data = 24'h22_2120; m3_ordy = 1'b1;

    // Power-on reset
    #12;
    check("por_ov",  32'(m4_ov),  32'h0);
    check("por_od",  32'(m4_od),  32'h0);
    check("por_oc",  32'(m4_oc),  32'h0);
    check("por_rdy", 32'(m4_rdy), 32'h0);
    check("por_ptr", 32'(u_dut4.rr_ptr_q), 32'h0);
    m4_vld = 4'b0000;
    reset  = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) begin
      m4_mode = vecs[i].mode;
      m4_sel  = vecs[i].sel;
      m4_vld  = vecs[i].vld;
      m4_data = vecs[i].data;
      m4_ordy = vecs[i].ordy;
      #1;
      check($sformatf("v%0d_rdy", i), 32'(m4_rdy), 32'(vecs[i].exp_rdy));
      tick();
      check($sformatf("v%0d_ov", i),  32'(m4_ov), 32'(vecs[i].exp_ov));
      check($sformatf("v%0d_od", i),  32'(m4_od), 32'(vecs[i].exp_od));
      check($sformatf("v%0d_oc", i),  32'(m4_oc), 32'(vecs[i].exp_oc));
      check($sformatf("v%0d_ptr", i), 32'(u_dut4.rr_ptr_q), 32'(vecs[i].exp_ptr));
    end

    // Backpressure: hold 0x55 from lane 1, then reload lane 2 on release
    m4_mode = 1'b1; m4_vld = 4'b0010; m4_data = 32'h1312_5510; m4_ordy = 1'b1;
    #1;
    check("bp_load_rdy", 32'(m4_rdy), 32'b0010);
    tick();
    check("bp_load_od", 32'(m4_od), 32'h55);
    m4_vld = 4'b1111; m4_ordy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp%0d_rdy", c), 32'(m4_rdy), 32'h0);
      tick();
      check($sformatf("bp%0d_ov", c),  32'(m4_ov), 32'h1);
      check($sformatf("bp%0d_od", c),  32'(m4_od), 32'h55);
      check($sformatf("bp%0d_oc", c),  32'(m4_oc), 32'd1);
      check($sformatf("bp%0d_ptr", c), 32'(u_dut4.rr_ptr_q), 32'd2);
    end
    m4_ordy = 1'b1;
    #1;
    check("bp_rel_rdy", 32'(m4_rdy), 32'b0100);
    tick();
    check("bp_rel_ov",  32'(m4_ov), 32'h1);
    check("bp_rel_od",  32'(m4_od), 32'h12);
    check("bp_rel_oc",  32'(m4_oc), 32'd2);
    check("bp_rel_ptr", 32'(u_dut4.rr_ptr_q), 32'd3);

    // Load 0xA5 from lane 2 (scan 3,0,1,2), then async reset mid-cycle
    m4_vld = 4'b0100; m4_data = 32'h13A5_5510;
    #1;
    check("rs_load_rdy", 32'(m4_rdy), 32'b0100);
    tick();
    check("rs_load_od",  32'(m4_od), 32'hA5);
    check("rs_load_ptr", 32'(u_dut4.rr_ptr_q), 32'd3);
    m4_vld = 4'b1111; m4_ordy = 1'b0;
    #3;
    reset   = 1'b1;
    m4_ordy = 1'b1;
    #1;
    check("rs_ov",  32'(m4_ov),  32'h0);
    check("rs_od",  32'(m4_od),  32'h0);
    check("rs_oc",  32'(m4_oc),  32'h0);
    check("rs_rdy", 32'(m4_rdy), 32'h0);
    check("rs_ptr", 32'(u_dut4.rr_ptr_q), 32'h0);
    @(posedge clk);
    #2;
    check("rs_edge_ov", 32'(m4_ov), 32'h0);
    reset = 1'b0;
    #1;
    check("rs_rel_rdy", 32'(m4_rdy), 32'b0001);
    tick();
    check("rs_rel_od", 32'(m4_od), 32'h10);
    check("rs_rel_oc", 32'(m4_oc), 32'd0);

    // Three-lane round-robin wraps 2 -> 0
    m4_vld = 4'b0000;
    m3_vld = 3'b111;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("n3_%0d_rdy", c), 32'(m3_rdy), 32'(3'b001 << (c % 3)));
      tick();
      check($sformatf("n3_%0d_ov", c), 32'(m3_ov), 32'h1);
      check($sformatf("n3_%0d_oc", c), 32'(m3_oc), 32'(c % 3));
      check($sformatf("n3_%0d_od", c), 32'(m3_od), 32'(8'h20 + 8'(c % 3)));
    end
    m3_mode = 1'b0; m3_sel = 2'd3;
    #1;
    check("n3_sel3_rdy", 32'(m3_rdy), 32'h0);
    tick();
    check("n3_sel3_ov", 32'(m3_ov), 32'h0);

`ifdef VALID_MUX_PARITY_EN
    m4_mode = 1'b0; m4_sel = 2'd0; m4_vld = 4'b0001; m4_ordy = 1'b1;
    m4_data = 32'h0000_0007;
    tick();
    check("par_07_od", 32'(m4_od),  32'h07);
    check("par_07",    32'(m4_par), 32'h1);
    m4_data = 32'h0000_0003;
    tick();
    check("par_03_od", 32'(m4_od),  32'h03);
    check("par_03",    32'(m4_par), 32'h0);
    m4_data = 32'h0000_0001; m4_ordy = 1'b0;
    tick();
    check("par_hold_od", 32'(m4_od),  32'h03);
    check("par_hold",    32'(m4_par), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/valid_mux_rr.md
Name: valid_mux_rr

Overview:
- Parametrised N-channel successor to the fixed 4:1 byte mux with per-lane valids.
- Selects one input lane per cycle and registers the word into a single output stage with ready/valid handshakes on every lane.
- Two modes: external selector, or internal round-robin that skips idle lanes.
- Sits between the lane sources and the downstream serializer/striping stage.

Parameters:
- N_CH, 4, number of input channels (2..16; need not be a power of two)
- DW, 8, data width per channel in bits
- SW, $clog2(N_CH), width of selector and channel index

Ports:
- clk  in  1  single system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- mode  in  1  0 = external select, 1 = round-robin
- sel  in  SW  channel index used when mode=0
- in_valid  in  N_CH  per-lane valid
- in_data  in  N_CH*DW  lane i occupies bits [i*DW +: DW]
- in_ready  out  N_CH  per-lane accept, one-hot or zero
- out_valid  out  1  registered output word valid
- out_data  out  DW  registered output word
- out_chan  out  SW  index of the lane that supplied out_data
- out_ready  in  1  downstream accept

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_chan=0, rr_ptr=0. in_ready is 0 while reset is high.
- Slot free: slot_free = !out_valid || out_ready.
- Transfers: a lane transfers when in_valid[i] && in_ready[i]. Output transfer: out_valid && out_ready.
- Latency: a word accepted in cycle t appears on out_data in cycle t+1. Full throughput is one word per cycle while out_ready=1.
- mode=0:
  - Candidate = sel.
  - in_ready[sel] = slot_free when sel < N_CH.
  - sel >= N_CH: no grant, all in_ready=0.
  - in_valid[sel]=0: no load. out_valid drops after the pending word is taken.
- mode=1:
  - Candidate = first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping from N_CH-1 to 0.
  - No valid lane: no grant, rr_ptr unchanged.
  - in_ready[candidate] = slot_free.
  - On transfer, rr_ptr <= (candidate+1) mod N_CH. Wrap uses an explicit compare, not power-of-two truncation.
- in_ready is combinational from in_valid, mode, sel, rr_ptr, out_valid and out_ready. It never depends on in_data.
- Load: on transfer, out_data <= lane data, out_chan <= candidate, out_valid <= 1.
- Output drained with no new grant: out_valid <= 0. out_data and out_chan hold their last value.
- Backpressure (out_valid=1, out_ready=0):
  - Output registers hold stable.
  - All in_ready=0.
  - rr_ptr frozen.
- Simultaneous drain and load in the same cycle: the new word replaces the old one, with no bubble.
- mode or sel change: affects the next arbitration only. A held output word is never altered. rr_ptr is retained across mode=0 periods and is not updated by grants made in mode=0.
- Reset mid-operation discards the held word. No lane is acknowledged in the reset cycle.

Optional Feature:
- Macro: VALID_MUX_PARITY_EN.
- Defined:
  - Adds output port out_par (1 bit), the even parity (XOR reduction) of out_data.
  - out_par is registered alongside out_data and resets to 0.
  - out_par holds with out_data under backpressure.
- Undefined: port and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package mux_pkg:
  - MODE_SEL=1'b0 and MODE_RR=1'b1.
  - Default DW/N_CH constants.
  - A function for index width.
- Sub-module rr_pick (purely combinational):
  - Inputs: req[N_CH] and ptr[SW].
  - Outputs: gnt_vld and gnt_idx[SW]. Rotating priority from ptr with correct wrap for non-power-of-two N_CH.
- Top-level valid_mux_rr owns rr_ptr, the output register stage and the handshake logic.

Test Plan:
- Reset check: assert reset asynchronously mid-cycle with out_valid=1 holding 0xA5 -> out_valid=0, out_data=0, in_ready=0 immediately; after release, rr_ptr=0.
- mode=0, sel=2, in_valid=4'b0100, lane2=0x3C, out_ready=1 -> in_ready=4'b0100. Next cycle out_valid=1, out_data=0x3C, out_chan=2. Repeat with sel=3 while lane3 is invalid -> out_valid=0 after one cycle.
- mode=1, all lanes valid with data 0x10/0x11/0x12/0x13, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3 with matching data and no bubbles.
- mode=1, in_valid=4'b1010 -> grants 1,3,1,3. With N_CH=3 and all valid -> 0,1,2,0 (wrap without index 3).
- Backpressure: out_valid=1 with 0x55, out_ready=0 for 3 cycles -> out_data stable at 0x55, in_ready=0, rr_ptr unchanged; release out_ready -> same-cycle reload with the next lane's word.
- VALID_MUX_PARITY_EN defined, out_data=0x07 -> out_par=1; out_data=0x03 -> out_par=0.
